// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_LDRESP = 3'd2,
        S_MERGE  = 3'd3,
        S_WR     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
    } op_t;

    // Stores only exist in byte/half/word form; unsigned variants are load-only.
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load extract/extend and SB/SH read-modify-write merge.
// dmem returns the word starting at the request address, so data sits in the low lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data_c,
    output logic [WIDTH-1:0] merged_c
);

    always_comb begin
        load_data_c = word;
        case (funct3)
            F3_B:    load_data_c = {{(WIDTH-8){word[7]}}, word[7:0]};
            F3_BU:   load_data_c = {{(WIDTH-8){1'b0}}, word[7:0]};
            F3_H:    load_data_c = {{(WIDTH-16){word[15]}}, word[15:0]};
            F3_HU:   load_data_c = {{(WIDTH-16){1'b0}}, word[15:0]};
            default: load_data_c = word;
        endcase
    end

    always_comb begin
        merged_c = word;
        case (funct3)
            F3_B:    merged_c[7:0]  = wdata[7:0];
            F3_H:    merged_c[15:0] = wdata[15:0];
            default: merged_c       = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: drives the byte-addressed dmem port for RV32I loads and stores,
// doing SB/SH as read-modify-write and trapping misaligned/illegal/out-of-range requests.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [WIDTH-1:0] ADDR_MAX = WIDTH'(MEM_DEPTH - 4);

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] load_data_c;
    logic [WIDTH-1:0] merged_c;
    logic             req_err_c;

    // Range check against MEM_DEPTH-4 keeps addr+3 inside memory without wrap.
    assign req_err_c = !f3_legal(store, funct3) || misaligned(funct3, addr[1:0]) ||
                       (addr > ADDR_MAX);
    assign busy      = (state != S_IDLE);

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3      (op.funct3),
        .word        (mem_rdata),
        .wdata       (wdata_q),
        .load_data_c (load_data_c),
        .merged_c    (merged_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= '0;
            wdata_q   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op      <= '{store: store, funct3: funct3};
                        wdata_q <= wdata;
                        if (req_err_c) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            mem_addr <= addr;
                            if (store && (funct3 == F3_W)) begin
                                state     <= S_WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end
                end
                S_RD:     state <= op.store ? S_MERGE : S_LDRESP;
                S_LDRESP: begin
                    rdata <= load_data_c;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_MERGE: begin
                    mem_wdata <= merged_c;
                    mem_we    <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: behavioural dmem, table-driven requests with a
// scoreboard queue popped on done, plus busy-ignore and mid-operation reset sequences.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned MEM_DEPTH = 1024;

    logic             clk;
    logic             rst;
    logic             req;
    logic             store;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    lsu #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .store     (store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: writes 4 bytes on we, registered word read one clock after addr.
    logic [7:0] mem [MEM_DEPTH];
    always @(posedge clk) begin
        if (mem_addr <= 32'(MEM_DEPTH - 4)) begin
            if (mem_we)
                for (int i = 0; i < 4; i++) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
            mem_rdata <= {mem[int'(mem_addr) + 3], mem[int'(mem_addr) + 2],
                          mem[int'(mem_addr) + 1], mem[int'(mem_addr)]};
        end else begin
            mem_rdata <= '0;
        end
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        string       name;
    } vec_t;

    typedef struct {
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          issue_cyc;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [31:0] hold_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every done and tracks mem_we activity.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            we_cyc = cyc;
        end
        if (!rst && err && !done) check("err_without_done", 32'(err), 32'(done));
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("spurious_done", 32'(done), 32'(0));
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, " err"}, 32'(err), 32'(mon_e.exp_err));
                check({mon_e.name, " rdata"}, rdata, mon_e.exp_rdata);
                check({mon_e.name, " latency"}, 32'(cyc - mon_e.issue_cyc), 32'(mon_e.exp_lat));
            end
        end
    end

    task automatic run(input vec_t v, input int ghost_at);
        exp_t e;
        int   we0;
        int   issue;
        bit   seen;
        int   exp_we;
        @(negedge clk);
        store  = v.st;
        funct3 = v.f3;
        addr   = v.a;
        wdata  = v.wd;
        req    = 1'b1;
        e.exp_err   = v.exp_err;
        e.exp_rdata = (v.st || v.exp_err) ? hold_rdata : v.exp_rdata;
        e.exp_lat   = v.exp_lat;
        e.issue_cyc = cyc;
        e.name      = v.name;
        sbq.push_back(e);
        if (!v.st && !v.exp_err) hold_rdata = v.exp_rdata;
        we0   = we_cnt;
        issue = cyc;
        seen  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req = (k == ghost_at);
            if (k == ghost_at) begin
                store  = 1'b1;
                funct3 = F3_W;
                addr   = 32'd8;
                wdata  = 32'h0BAD0BAD;
            end
            #1;
            if (sbq.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        req = 1'b0;
        if (!seen) begin
            check({v.name, " timeout"}, 32'(sbq.size()), 32'(0));
            sbq.delete();
        end
        @(negedge clk);
        check({v.name, " busy_after"}, 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        exp_we = (v.st && !v.exp_err) ? 1 : 0;
        check({v.name, " we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we == 1) check({v.name, " we_cycle"}, 32'(we_cyc - issue), 32'(v.exp_lat - 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   we0;
        for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 8'h00;
        mem[0] = 8'h80; mem[1] = 8'h7F; mem[2] = 8'h01; mem[3] = 8'h02;
        mem[4] = 8'h00; mem[5] = 8'h90;
        mem[1020] = 8'h11; mem[1021] = 8'h22; mem[1022] = 8'h33; mem[1023] = 8'h44;

        tbl.push_back('{1'b0, F3_B,   32'd0,    32'h0,        1'b0, 32'hFFFFFF80, 3, "LB_0"});
        tbl.push_back('{1'b0, F3_BU,  32'd0,    32'h0,        1'b0, 32'h00000080, 3, "LBU_0"});
        tbl.push_back('{1'b0, F3_H,   32'd0,    32'h0,        1'b0, 32'h00007F80, 3, "LH_0"});
        tbl.push_back('{1'b0, F3_W,   32'd0,    32'h0,        1'b0, 32'h02017F80, 3, "LW_0"});
        tbl.push_back('{1'b0, F3_H,   32'd4,    32'h0,        1'b0, 32'hFFFF9000, 3, "LH_4"});
        tbl.push_back('{1'b0, F3_HU,  32'd4,    32'h0,        1'b0, 32'h00009000, 3, "LHU_4"});
        tbl.push_back('{1'b0, F3_B,   32'd1,    32'h0,        1'b0, 32'h0000007F, 3, "LB_1"});
        tbl.push_back('{1'b1, F3_W,   32'd8,    32'hDEADBEEF, 1'b0, 32'h0,        2, "SW_8"});
        tbl.push_back('{1'b0, F3_W,   32'd8,    32'h0,        1'b0, 32'hDEADBEEF, 3, "LW_8a"});
        tbl.push_back('{1'b1, F3_B,   32'd8,    32'h000000AA, 1'b0, 32'h0,        4, "SB_8"});
        tbl.push_back('{1'b0, F3_W,   32'd8,    32'h0,        1'b0, 32'hDEADBEAA, 3, "LW_8b"});
        tbl.push_back('{1'b1, F3_H,   32'd8,    32'h00001234, 1'b0, 32'h0,        4, "SH_8"});
        tbl.push_back('{1'b0, F3_W,   32'd8,    32'h0,        1'b0, 32'hDEAD1234, 3, "LW_8c"});
        tbl.push_back('{1'b1, F3_B,   32'd10,   32'h00000055, 1'b0, 32'h0,        4, "SB_10"});
        tbl.push_back('{1'b0, F3_W,   32'd8,    32'h0,        1'b0, 32'hDE551234, 3, "LW_8d"});
        tbl.push_back('{1'b0, F3_W,   32'd2,    32'h0,        1'b1, 32'h0,        1, "trap_LW_2"});
        tbl.push_back('{1'b1, F3_H,   32'd1,    32'h0,        1'b1, 32'h0,        1, "trap_SH_1"});
        tbl.push_back('{1'b0, 3'b011, 32'd0,    32'h0,        1'b1, 32'h0,        1, "trap_f3_011"});
        tbl.push_back('{1'b0, F3_W,   32'd1022, 32'h0,        1'b1, 32'h0,        1, "trap_LW_1022"});
        tbl.push_back('{1'b0, F3_B,   32'd1021, 32'h0,        1'b1, 32'h0,        1, "trap_LB_1021"});
        tbl.push_back('{1'b1, F3_BU,  32'd0,    32'h0,        1'b1, 32'h0,        1, "trap_store_f3_100"});
        tbl.push_back('{1'b0, F3_W,   32'd1020, 32'h0,        1'b0, 32'h44332211, 3, "LW_1020"});
        tbl.push_back('{1'b1, F3_W,   32'd1020, 32'hCAFEF00D, 1'b0, 32'h0,        2, "SW_1020"});
        tbl.push_back('{1'b0, F3_W,   32'd1020, 32'h0,        1'b0, 32'hCAFEF00D, 3, "LW_1020b"});

        rst = 1'b1; req = 1'b0; store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
        hold_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset done", 32'(done), 32'(0));
        check("reset err", 32'(err), 32'(0));
        check("reset mem_we", 32'(mem_we), 32'(0));
        check("reset rdata", rdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], 0);

        // Spurious SW pulsed while a load is in flight must be dropped.
        v = '{1'b0, F3_W, 32'd8, 32'h0, 1'b0, 32'hDE551234, 3, "LW_ghost"};
        run(v, 1);
        v = '{1'b0, F3_W, 32'd8, 32'h0, 1'b0, 32'hDE551234, 3, "LW_after_ghost"};
        run(v, 0);

        // Reset during the MERGE cycle of an SB: no write, no done.
        @(negedge clk);
        store = 1'b1; funct3 = F3_B; addr = 32'd8; wdata = 32'h00000077; req = 1'b1;
        we0 = we_cnt;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold_rdata = 32'h0;
        repeat (5) @(negedge clk);
        check("rst_abort we_count", 32'(we_cnt - we0), 32'(0));
        check("rst_abort busy", 32'(busy), 32'(0));
        check("rst_abort rdata", rdata, 32'h0);
        v = '{1'b0, F3_W, 32'd8, 32'h0, 1'b0, 32'hDE551234, 3, "LW_after_rst"};
        run(v, 0);

        repeat (4) @(negedge clk);
        check("final queue empty", 32'(sbq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
